// File: rtl/mdu_ex.sv
// Iterative multiply/divide unit for the EX stage.
// Runs MULT/MULTU/DIV/DIVU as 32 shift-add or restoring-divide steps, then one
// sign-fixup cycle. MTHI/MTLO complete at the accepting edge. All state moves
// on the falling clock edge, as the rest of the pipeline does.
module mdu_ex #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] HI_result,
  output logic [DATA_W-1:0] LO_result,
  output logic              HI_Wr,
  output logic              LO_Wr,
  output logic              div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);
  localparam logic [5:0] CNT_SAT   = 6'(DATA_W);

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [DATA_W-1:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
  logic                  neg_q, neg_d;     // product sign or quotient sign
  logic                  rneg_q, rneg_d;   // remainder sign
  logic                  is_div_q, is_div_d;
  logic                  dz_q, dz_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  hi_wr_q, hi_wr_d;
  logic                  lo_wr_q, lo_wr_d;
  logic                  dzf_q, dzf_d;

  logic                  sgn_op;
  logic [DATA_W:0]       mul_sum;
  logic [DATA_W:0]       rem_sh;           // 33-bit partial remainder after the shift
  logic                  rem_ge;
  logic [DATA_W-1:0]     rem_sub;
  logic [2*DATA_W-1:0]   prod;

  // Absolute value of a possibly signed operand; 0x80000000 maps to itself.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    return (sgn && (s < 0)) ? $unsigned(-s) : v;
  endfunction

  // Conditional two's-complement negation of a single-width value.
  function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] v, input logic c);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    return c ? $unsigned(-s) : v;
  endfunction

  // Conditional two's-complement negation of the double-width product.
  function automatic logic [2*DATA_W-1:0] cneg_dw(input logic [2*DATA_W-1:0] v, input logic c);
    logic signed [2*DATA_W-1:0] s;
    s = $signed(v);
    return c ? $unsigned(-s) : v;
  endfunction

  // Control and result registers; reset clears them and overrides start/flush.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_wr_q <= 1'b0;
      lo_wr_q <= 1'b0;
      dzf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_wr_q <= hi_wr_d;
      lo_wr_q <= lo_wr_d;
      dzf_q   <= dzf_d;
    end
  end

  // Datapath registers; only meaningful while an op is in flight, so no reset.
  always_ff @(negedge clk) begin
    acc_q    <= acc_d;
    opb_q    <= opb_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
    is_div_q <= is_div_d;
    dz_q     <= dz_d;
  end

  // Next-state and datapath step: accept, iterate, fix up signs, complete.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_wr_d  = 1'b0;
    lo_wr_d  = 1'b0;
    dzf_d    = 1'b0;

    sgn_op  = (op == 3'b000) || (op == 3'b010);
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opb_q};
    rem_sh  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    rem_ge  = rem_sh >= {1'b0, opb_q};
    // When rem_ge holds the difference is below the divisor, so 32 bits suffice.
    rem_sub = rem_sh[DATA_W-1:0] - opb_q;
    prod    = cneg_dw(acc_q, neg_q);

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          unique case (op)
            3'b000, 3'b001: begin
              acc_d    = {{DATA_W{1'b0}}, mag(src_a, sgn_op)};
              opb_d    = mag(src_b, sgn_op);
              neg_d    = sgn_op && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
              is_div_d = 1'b0;
              dz_d     = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            3'b010, 3'b011: begin
              is_div_d = 1'b1;
              if (src_b == '0) begin
                // Divide by zero skips iteration; HI carries the dividend.
                acc_d   = {src_a, {DATA_W{1'b0}}};
                dz_d    = 1'b1;
                state_d = S_FIX;
              end else begin
                acc_d   = {{DATA_W{1'b0}}, mag(src_a, sgn_op)};
                opb_d   = mag(src_b, sgn_op);
                neg_d   = sgn_op && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                rneg_d  = sgn_op && src_a[DATA_W-1];
                dz_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
            3'b100: begin
              hi_d    = src_a;
              hi_wr_d = 1'b1;
            end
            3'b101: begin
              lo_d    = src_a;
              lo_wr_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[DATA_W-1:1]};
          else          acc_d = {1'b0, acc_q[2*DATA_W-1:1]};
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (rem_ge) acc_d = {rem_sub, acc_q[DATA_W-2:0], 1'b1};
          else        acc_d = {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_wr_d = 1'b1;
          lo_wr_d = 1'b1;
          if (dz_q) begin
            hi_d  = acc_q[2*DATA_W-1:DATA_W];
            lo_d  = DIV0_LO;
            dzf_d = 1'b1;
          end else if (is_div_q) begin
            lo_d = cneg(acc_q[DATA_W-1:0], neg_q);
            hi_d = cneg(acc_q[2*DATA_W-1:DATA_W], rneg_q);
          end else begin
            hi_d = prod[2*DATA_W-1:DATA_W];
            lo_d = prod[DATA_W-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come straight from registers; busy covers every non-idle state.
  always_comb begin
    busy        = (state_q != S_IDLE);
    HI_result   = hi_q;
    LO_result   = lo_q;
    HI_Wr       = hi_wr_q;
    LO_Wr       = lo_wr_q;
    div_by_zero = dzf_q;
  end

endmodule

// File: tb/tb_mdu_ex.sv
// Directed bench for mdu_ex: vector table for complete ops plus hand-written
// sequences for ignored starts, flush, reset mid-op and back-to-back issue.
// DUT state moves on negedge; the bench drives and samples on posedge.
module tb_mdu_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy;
  logic [31:0] HI_result, LO_result;
  logic        HI_Wr, LO_Wr, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        hwr, lwr, dz;
    int          busy_n;
  } vec_t;

  vec_t vecs[14];

  mdu_ex dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .HI_result(HI_result), .LO_result(LO_result),
    .HI_Wr(HI_Wr), .LO_Wr(LO_Wr), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at the current posedge and follow it to its completion strobe.
  task automatic run_op(input vec_t v);
    int  bn;
    bit  done;
    bn = 0;
    done = 1'b0;
    op = v.op; src_a = v.a; src_b = v.b; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (busy) bn++;
      if (HI_Wr || LO_Wr) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    chk({v.name, "_done"}, 64'(done), 64'd1);
    chk({v.name, "_busy_cycles"}, 64'(bn), 64'(v.busy_n));
    chk({v.name, "_strobes"}, {61'd0, HI_Wr, LO_Wr, div_by_zero}, {61'd0, v.hwr, v.lwr, v.dz});
    chk({v.name, "_hi"}, 64'(HI_result), 64'(v.hi));
    chk({v.name, "_lo"}, 64'(LO_result), 64'(v.lo));
    @(posedge clk);
    chk({v.name, "_strobe_drop"}, {61'd0, HI_Wr, LO_Wr, div_by_zero}, 64'd0);
  endtask

  // Advance until the n-th busy cycle has been observed.
  task automatic reach_busy(input string name, input int n);
    int bn;
    bn = 0;
    for (int k = 0; k < 50; k++) begin
      if (busy) bn++;
      if (bn == n) break;
      @(posedge clk);
    end
    chk(name, 64'(bn), 64'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   ns;
    vecs[0]  = '{"mult_neg6",   3'b000, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1, 1, 0, 33};
    vecs[1]  = '{"multu_max",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, 1, 0, 33};
    vecs[2]  = '{"div_m7_2",    3'b010, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1, 0, 33};
    vecs[3]  = '{"div_minneg",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1, 1, 0, 33};
    vecs[4]  = '{"divu_by0",    3'b011, 32'h7,        32'h0,        32'h7,        32'hFFFFFFFF, 1, 1, 1, 1};
    vecs[5]  = '{"divu_100_7",  3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       1, 1, 0, 33};
    vecs[6]  = '{"mult_7_m5",   3'b000, 32'h7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1, 1, 0, 33};
    vecs[7]  = '{"div_7_m2",    3'b010, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1, 1, 0, 33};
    vecs[8]  = '{"divu_big",    3'b011, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1, 1, 0, 33};
    vecs[9]  = '{"mthi",        3'b100, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0FFFFFFF, 1, 0, 0, 0};
    vecs[10] = '{"mtlo",        3'b101, 32'h1234,     32'h0,        32'hDEADBEEF, 32'h00001234, 0, 1, 0, 0};
    vecs[11] = '{"div_by0_s",   3'b010, 32'h80000000, 32'h0,        32'h80000000, 32'hFFFFFFFF, 1, 1, 1, 1};
    vecs[12] = '{"multu_shift", 3'b001, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1, 1, 0, 33};
    vecs[13] = '{"mult_minsq",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1, 1, 0, 33};

    // Reset with a start pending: reset must win.
    rst = 1'b0; flush = 1'b0; start = 1'b1; op = 3'b100; src_a = 32'hAAAA; src_b = '0;
    @(posedge clk);
    @(posedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(HI_result), 64'd0);
    chk("reset_lo", 64'(LO_result), 64'd0);
    chk("reset_strobes", {61'd0, HI_Wr, LO_Wr, div_by_zero}, 64'd0);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // Start asserted while busy must be ignored.
    op = 3'b001; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    op = 3'b100; src_a = 32'h55; start = 1'b1;
    repeat (5) @(posedge clk);
    start = 1'b0;
    reach_busy("busy_start_reach", 24);
    for (int k = 0; k < 50 && !(HI_Wr || LO_Wr); k++) @(posedge clk);
    chk("busy_start_hi", 64'(HI_result), 64'hFFFFFFFE);
    chk("busy_start_lo", 64'(LO_result), 64'h1);
    ns = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      if (HI_Wr || LO_Wr || busy) ns++;
    end
    chk("busy_start_no_extra", 64'(ns), 64'd0);
    chk("busy_start_hi_kept", 64'(HI_result), 64'hFFFFFFFE);

    // Flush on the 10th busy cycle, then MTLO right after.
    op = 3'b000; src_a = 32'h3; src_b = 32'h4; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    reach_busy("flush_reach", 10);
    flush = 1'b1;
    @(posedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_strobes", {62'd0, HI_Wr, LO_Wr}, 64'd0);
    chk("flush_results", {HI_result, LO_result}, {32'hFFFFFFFE, 32'h1});
    op = 3'b101; src_a = 32'h1234; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    chk("mtlo_after_flush_lo", 64'(LO_result), 64'h1234);
    chk("mtlo_after_flush_strobes", {61'd0, HI_Wr, LO_Wr, busy}, {61'd0, 1'b0, 1'b1, 1'b0});
    chk("mtlo_after_flush_hi", 64'(HI_result), 64'hFFFFFFFE);
    ns = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (HI_Wr || LO_Wr || busy) ns++;
    end
    chk("flush_no_late_completion", 64'(ns), 64'd0);

    // Flush on the edge where FIX would complete.
    op = 3'b000; src_a = 32'h5; src_b = 32'h6; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    reach_busy("fixflush_reach", 33);
    flush = 1'b1;
    @(posedge clk);
    flush = 1'b0;
    chk("fixflush_strobes", {61'd0, HI_Wr, LO_Wr, busy}, 64'd0);
    chk("fixflush_results", {HI_result, LO_result}, {32'hFFFFFFFE, 32'h1234});

    // Undefined op, then a start qualified by flush: both ignored.
    op = 3'b110; src_a = 32'h99; src_b = 32'h3; start = 1'b1;
    @(posedge clk);
    chk("undef_op", {61'd0, HI_Wr, LO_Wr, busy}, 64'd0);
    op = 3'b100; flush = 1'b1;
    @(posedge clk);
    start = 1'b0; flush = 1'b0;
    @(posedge clk);
    chk("start_with_flush", {61'd0, HI_Wr, LO_Wr, busy}, 64'd0);
    chk("ignored_results", {HI_result, LO_result}, {32'hFFFFFFFE, 32'h1234});

    // Back-to-back: MTHI presented in the completion cycle of a MULTU.
    op = 3'b001; src_a = 32'h2; src_b = 32'h3; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !(HI_Wr || LO_Wr); k++) @(posedge clk);
    chk("b2b_mul", {HI_result, LO_result}, {32'h0, 32'h6});
    op = 3'b100; src_a = 32'h77; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    chk("b2b_mthi_strobes", {62'd0, HI_Wr, LO_Wr}, {62'd0, 1'b1, 1'b0});
    chk("b2b_mthi_results", {HI_result, LO_result}, {32'h77, 32'h6});

    // Reset in the middle of a DIV, then a clean DIVU.
    op = 3'b010; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    reach_busy("rstmid_reach", 20);
    rst = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_results", {HI_result, LO_result}, 64'd0);
    chk("rstmid_strobes", {61'd0, HI_Wr, LO_Wr, div_by_zero}, 64'd0);
    v = '{"divu_after_rst", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1, 1, 0, 33};
    run_op(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
